uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Standalone UART receiver: 16x-oversampled, with a 2-FF input synchronizer, majority-vote bit sampling, optional parity check and framing check.
It is the receive end for the team's UART transmitter (tx_output_serial).
- Delivers one byte per frame to a register interface.
- Signals a new byte with a sticky rx_flag, cleared by rx_flag_clr.
- Reports parity, framing and overrun errors.

Parameters:
CLK_FREQ, 25_000_000, input clock frequency in Hz
BAUD, 9600, line rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8
DATA_BITS, 8, data bits per frame (5..8), LSB first
PARITY_EN, 1, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, idle high, asynchronous to clk
rx_flag_clr  input  1  one-cycle pulse that clears rx_flag and overrun
Rx_Data  output  8  last received byte, zero-extended when DATA_BITS < 8
rx_flag  output  1  sticky "new byte available" flag
parity_error  output  1  parity result of the last frame
framing_error  output  1  stop bit was sampled low in the last frame
overrun  output  1  a frame completed while rx_flag was still set
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst=1):
  - Rx_Data=0; rx_flag, parity_error, framing_error, overrun, busy=0.
  - Both synchronizer flops=1.
  - FSM=IDLE; tick and bit counters=0.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation, minimum 1.
  - Produces a one-cycle tick every DIV clocks; free-running.
  - Restarts at 0 on entry to START so sampling phase aligns to the detected edge.
- Sample counter s runs 0..OVERSAMPLE-1 per bit and advances on each tick.
  - Bit value = majority of the synchronized samples at s = M-1, M, M+1, where M = OVERSAMPLE/2.
  - The bit is evaluated at s = M+1.
- FSM:
  - IDLE: on a synchronized high->low transition, go to START; busy=1.
  - START: at s=M+1, majority=1 is a glitch → IDLE with no flag or error change. Majority=0 → DATA at bit end (s wraps to 0).
  - DATA: shift in DATA_BITS bits LSB first. After the last bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample the parity bit. perr = (XOR of data bits) XOR parity_bit XOR PARITY_ODD.
  - STOP: evaluate at s=M+1, then go to IDLE immediately; no wait for the full stop bit, so back-to-back frames are tolerated.
- Frame commit, on the clock after the stop-bit evaluation. All fields update together in one cycle:
  - Rx_Data is written.
  - parity_error = perr (0 if PARITY_EN=0).
  - framing_error = !stop_sample.
  - rx_flag = 1.
  - Data is written even when errors are present.
- Overrun: a commit while rx_flag=1 and rx_flag_clr=0 sets overrun=1; the new data overwrites Rx_Data.
- rx_flag_clr:
  - Clears rx_flag and overrun.
  - Does not clear parity_error or framing_error; those are overwritten by the next commit.
- Commit and rx_flag_clr in the same cycle: rx_flag=1, overrun unchanged (clr is ignored for overrun; the new byte wins).
- rx held low (break): the frame completes with framing_error=1. The FSM then waits in IDLE for rx to return high before a new start can be detected; a falling edge is required.
- Reset mid-frame: immediate abort to the reset state; the partial byte is discarded.
- Latency: the synchronizer adds 2 clk from pin to FSM.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Function calc_div(CLK_FREQ, BAUD, OVERSAMPLE).
  - Constant IDLE_LEVEL=1'b1.
  - Shared with the transmitter.
- Sub-module uart_baud_tick: parameter DIV; ports clk, rst, restart; output tick.
  - Reusable by the transmitter with OVERSAMPLE=1.

Test Plan:
Common setup for all scenarios: CLK_FREQ=16, BAUD=1, OVERSAMPLE=16 (DIV=1, 16 clk/bit), PARITY_EN=1, even parity; clk period 40 ns.
1. Frame 0x57 (start, bits LSB first, parity 1, stop) → Rx_Data=0x57, rx_flag=1, parity_error=0, framing_error=0, busy=0 after commit; pulse rx_flag_clr → rx_flag=0, Rx_Data stays 0x57.
2. Frame 0xA5 with parity bit forced to 1 (correct is 0) → Rx_Data=0xA5, parity_error=1, rx_flag=1.
3. Frame 0x3C with stop bit 0 → framing_error=1, Rx_Data=0x3C; hold rx low 40 clk → no second frame; release, send 0x01 → framing_error=0, Rx_Data=0x01.
4. rx low for 5 clk only (glitch) → no commit: rx_flag=0, busy returns to 0, Rx_Data unchanged.
5. Two back-to-back frames 0x11 then 0x22 with no clr → Rx_Data=0x22, rx_flag=1, overrun=1; clr pulse → rx_flag=0, overrun=0. Repeat with clr coincident with the second commit → rx_flag=1, overrun=0.
6. Assert rst mid-DATA after 4 bits of 0xFF → all outputs 0 immediately (asynchronous); the next full frame 0x80 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_t : receiver frame FSM states
//   IDLE_LEVEL   : electrical level of an idle serial line
//   calc_div     : clocks per oversample tick, truncated, never below 1
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV clocks.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   restart : forces the divider back to phase 0 (no tick in that cycle)
//   tick    : one-cycle pulse every DIV clocks
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (restart || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver with majority-vote sampling,
// optional parity check, framing check and overrun detection.
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset
//   rx            : serial line, idle high, asynchronous to clk
//   rx_flag_clr   : one-cycle pulse clearing rx_flag and overrun
//   Rx_Data       : last received byte, zero-extended
//   rx_flag       : sticky "new byte available"
//   parity_error  : parity result of the last frame
//   framing_error : stop bit sampled low in the last frame
//   overrun       : a frame completed while rx_flag was still set
//   busy          : FSM not in IDLE
`timescale 1ns/1ps
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_flag_clr,
  output logic [7:0] Rx_Data,
  output logic       rx_flag,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_M_LO   = SW'(M - 1);
  localparam logic [SW-1:0] S_M      = SW'(M);
  localparam logic [SW-1:0] S_M_HI   = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0);
  localparam logic          ODD_BIT  = (PARITY_ODD != 0);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_state_t         state, state_nxt;
  logic                rx_p0, rx_p1, rx_p2;
  logic                tick, restart;
  logic [SW-1:0]       s_cnt;
  logic [BW-1:0]       bit_cnt;
  logic                samp_lo, samp_mid;
  logic [DATA_BITS-1:0] shift;
  logic                par_bit;
  logic                eval, bit_end, bit_val;
  logic                shift_en, par_en, stop_en;
  logic                vld_p1, stop_p1;
  logic                perr;

  // ---- stage p0: two-flop synchronizer, plus one extra flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= IDLE_LEVEL;
      rx_p1 <= IDLE_LEVEL;
      rx_p2 <= IDLE_LEVEL;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Bit value is voted from samples at M-1, M and the live sample at M+1.
  assign bit_val = majority3(samp_lo, samp_mid, rx_p1);
  assign eval    = tick && (s_cnt == S_M_HI);
  assign bit_end = tick && (s_cnt == S_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    case (state)
      IDLE: begin
        // A falling edge is required, so a held-low line cannot retrigger.
        if (rx_p2 && !rx_p1) begin
          state_nxt = START;
          restart   = 1'b1;
        end
      end
      START: begin
        if (eval && bit_val)
          state_nxt = IDLE;
        else if (bit_end)
          state_nxt = DATA;
      end
      DATA: begin
        shift_en = eval;
        if (bit_end && bit_cnt == LAST_BIT)
          state_nxt = PAR_ON ? PARITY : STOP;
      end
      PARITY: begin
        par_en = eval;
        if (bit_end)
          state_nxt = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (eval) begin
          stop_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE)
        s_cnt <= '0;
      else if (tick)
        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);

      if (restart)
        bit_cnt <= '0;
      else if (state == DATA && bit_end && bit_cnt != LAST_BIT)
        bit_cnt <= bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tick && s_cnt == S_M_LO)
      samp_lo <= rx_p1;
    if (tick && s_cnt == S_M)
      samp_mid <= rx_p1;
    if (shift_en)
      shift <= {bit_val, shift[DATA_BITS-1:1]};
    if (par_en)
      par_bit <= bit_val;
    if (stop_en)
      stop_p1 <= bit_val;
  end

  // ---- stage p1: frame commit, one clock after the stop-bit evaluation
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= stop_en;
  end

  assign perr = PAR_ON & ((^shift) ^ par_bit ^ ODD_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Rx_Data       <= '0;
      rx_flag       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (vld_p1) begin
      Rx_Data       <= 8'(shift);
      parity_error  <= perr;
      framing_error <= !stop_p1;
      rx_flag       <= 1'b1;
      // A clear arriving with the commit is consumed by the new byte.
      if (rx_flag && !rx_flag_clr)
        overrun <= 1'b1;
    end else if (rx_flag_clr) begin
      rx_flag <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int   CLK_FREQ   = 16;
  localparam int   BAUD       = 1;
  localparam int   OVERSAMPLE = 16;
  localparam int   DATA_BITS  = 8;
  localparam int   PARITY_EN  = 1;
  localparam int   PARITY_ODD = 0;
  localparam int   BIT_CLKS   = 16;
  localparam logic ODD_BIT    = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       flag;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_flag_clr;
  logic [7:0] Rx_Data;
  logic       rx_flag;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  logic model_flag;
  logic model_ov;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_flag_clr   (rx_flag_clr),
    .Rx_Data       (Rx_Data),
    .rx_flag       (rx_flag),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame, starting and ending on a falling clock edge, and
  // pushes the expected commit result into the scoreboard.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                            input bit clr_at_commit);
    exp_t e;
    logic pbit;
    bit   clr_done;
    pbit   = (^d) ^ ODD_BIT ^ bad_par;
    e.data = d;
    e.perr = (^d) ^ pbit ^ ODD_BIT;
    e.ferr = !stop;
    e.flag = 1'b1;
    e.ov   = model_ov | (model_flag & !clr_at_commit);
    model_flag = 1'b1;
    model_ov   = e.ov;
    sb.push_back(e);

    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = pbit;
    repeat (BIT_CLKS) @(negedge clk);
    rx = stop;
    clr_done = 0;
    for (int i = 0; i < BIT_CLKS; i++) begin
      // busy drops at the stop evaluation; the commit is on the next edge.
      if (clr_at_commit && !clr_done && !busy) begin
        rx_flag_clr = 1'b1;
        clr_done    = 1;
      end else begin
        rx_flag_clr = 1'b0;
      end
      @(negedge clk);
    end
    rx_flag_clr = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_data"},  32'(Rx_Data),       32'(e.data));
    check({tag, "_perr"},  32'(parity_error),  32'(e.perr));
    check({tag, "_ferr"},  32'(framing_error), 32'(e.ferr));
    check({tag, "_flag"},  32'(rx_flag),       32'(e.flag));
    check({tag, "_ovr"},   32'(overrun),       32'(e.ov));
    check({tag, "_busy"},  32'(busy),          32'd0);
  endtask

  task automatic clr_pulse();
    rx_flag_clr = 1'b1;
    @(negedge clk);
    rx_flag_clr = 1'b0;
    model_flag  = 1'b0;
    model_ov    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(Rx_Data),       32'd0);
    check({tag, "_flag"}, 32'(rx_flag),       32'd0);
    check({tag, "_perr"}, 32'(parity_error),  32'd0);
    check({tag, "_ferr"}, 32'(framing_error), 32'd0);
    check({tag, "_ovr"},  32'(overrun),       32'd0);
    check({tag, "_busy"}, 32'(busy),          32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    model_flag  = 1'b0;
    model_ov    = 1'b0;
    rst         = 1'b1;
    rx          = 1'b1;
    rx_flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: clean frame, then clear
    send_frame(8'h57, 0, 1, 0);
    check_frame("f57");
    clr_pulse();
    check("f57_clr_flag", 32'(rx_flag), 32'd0);
    check("f57_clr_data", 32'(Rx_Data), 32'h57);

    // 2: wrong parity bit
    send_frame(8'hA5, 1, 1, 0);
    check_frame("fA5_par");
    clr_pulse();

    // 3: framing error, held-low break, then recovery
    send_frame(8'h3C, 0, 0, 0);
    check_frame("f3C_frm");
    clr_pulse();
    repeat (40) @(negedge clk);
    check("break_flag", 32'(rx_flag), 32'd0);
    check("break_busy", 32'(busy),    32'd0);
    check("break_data", 32'(Rx_Data), 32'h3C);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h01, 0, 1, 0);
    check_frame("f01");
    clr_pulse();

    // 4: short low glitch is rejected
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_flag", 32'(rx_flag), 32'd0);
    check("glitch_busy", 32'(busy),    32'd0);
    check("glitch_data", 32'(Rx_Data), 32'h01);

    // 5: back-to-back frames, overrun, then clear coincident with commit
    send_frame(8'h11, 0, 1, 0);
    check_frame("f11");
    send_frame(8'h22, 0, 1, 0);
    check_frame("f22_ovr");
    clr_pulse();
    check("ovr_clr_flag", 32'(rx_flag), 32'd0);
    check("ovr_clr_ovr",  32'(overrun), 32'd0);
    send_frame(8'h44, 0, 1, 0);
    check_frame("f44");
    send_frame(8'h55, 0, 1, 1);
    check_frame("f55_coinc");

    // 6: asynchronous reset mid-DATA, then a fresh frame
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + 8) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #5;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_flag = 1'b0;
    model_ov   = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h80, 0, 1, 0);
    check_frame("f80");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
